// File: rtl/bcd_key_entry_if.sv
// rtl/bcd_key_entry_if.sv - committed-result bus of the BCD key entry unit
interface bcd_key_entry_if #(
    parameter int OUT_W = 10
);
    logic [OUT_W-1:0] VALUE;
    logic             VALID;
    logic             OVF;
    logic             BUSY;
    logic             NEG;

    modport master (output VALUE, output VALID, output OVF, output BUSY, output NEG);
    modport slave  (input  VALUE, input  VALID, input  OVF, input  BUSY, input  NEG);
endinterface

// File: rtl/bcd_key_entry.sv
// rtl/bcd_key_entry.sv - push-button BCD operand entry with serial BCD-to-binary commit (option: BCD_KEY_ENTRY_SIGN_EN)
module bcd_key_entry #(
    parameter int DIGITS     = 3,
    parameter int OUT_W      = 10,
    parameter int DEB_CYCLES = 50000
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [3:0]            KEY,
    output logic [4*DIGITS-1:0]   DIGIT,
    output logic [DIGITS-1:0]     CURSOR,
    bcd_key_entry_if.master       res
);

`ifdef BCD_KEY_ENTRY_SIGN_EN
    localparam int NK = 4;
`else
    localparam int NK = 3;
`endif
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam int ACC_W = $clog2(10 ** DIGITS);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW    = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    typedef enum logic [1:0] {ENTRY, CONV, DONE} state_t;

    logic [NK-1:0] press;
    logic          p3;

    for (genvar g = 0; g < NK; g++) begin : g_key
        logic [1:0]       sync_q;
        logic             deb_q;
        logic             deb_dly_q;
        logic [CNT_W-1:0] cnt_q;

        // Synchronise the raw button, then accept a new level only after it has been stable long enough
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                sync_q    <= 2'b11;
                deb_q     <= 1'b1;
                deb_dly_q <= 1'b1;
                cnt_q     <= '0;
            end else begin
                sync_q    <= {sync_q[0], KEY[g]};
                deb_dly_q <= deb_q;
                if (sync_q[1] == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                    deb_q <= sync_q[1];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign press[g] = deb_dly_q & ~deb_q;
    end

`ifdef BCD_KEY_ENTRY_SIGN_EN
    assign p3 = press[NK-1];
`else
    logic unused_key3;
    assign unused_key3 = KEY[3];
    assign p3 = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] digit_q, digit_d;
    logic [DIGITS-1:0]   cursor_q, cursor_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [OUT_W-1:0]    value_q, value_d;
    logic                ovf_q, ovf_d;
    logic                neg_q, neg_d;
    logic                sign_q, sign_d;
    logic [3:0]          cur_digit;
    logic [CW-1:0]       acc_ext;

    assign cur_digit = digit_q[{idx_q, 2'b00} +: 4];

    // State and datapath registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ENTRY;
            digit_q  <= '0;
            cursor_q <= DIGITS'(1);
            acc_q    <= '0;
            idx_q    <= '0;
            value_q  <= '0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            cursor_q <= cursor_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            value_q  <= value_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            sign_q   <= sign_d;
        end
    end

    // Next state: key editing in ENTRY, MSD-first multiply-accumulate in CONV, result loaded on entry to DONE
    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        cursor_d = cursor_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        value_d  = value_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        sign_d   = sign_q;
        acc_ext  = '0;
        case (state_q)
            ENTRY: begin
                if (press[2]) begin
                    acc_d   = '0;
                    idx_d   = IDX_W'(DIGITS - 1);
                    state_d = CONV;
                end else if (press[1]) begin
                    cursor_d = (cursor_q << 1) | (cursor_q >> (DIGITS - 1));
                end else if (press[0]) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cursor_q[i]) begin
                            digit_d[4*i +: 4] = (digit_q[4*i +: 4] == 4'd9) ? 4'd0 : digit_q[4*i +: 4] + 4'd1;
                        end
                    end
                end else if (p3) begin
                    sign_d = ~sign_q;
                end
            end
            CONV: begin
                acc_d = (acc_q << 3) + (acc_q << 1) + ACC_W'(cur_digit);
                if (idx_q == '0) begin
                    // Load the result now so VALUE is already current during the VALID cycle
                    acc_ext = CW'(acc_d);
                    ovf_d   = acc_ext > CW'({OUT_W{1'b1}});
                    value_d = ovf_d ? {OUT_W{1'b1}} : OUT_W'(acc_ext);
                    neg_d   = sign_q;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = ENTRY;
            end
            default: begin
                state_d = ENTRY;
            end
        endcase
    end

    assign DIGIT     = digit_q;
    assign CURSOR    = cursor_q;
    assign res.VALUE = value_q;
    assign res.VALID = (state_q == DONE);
    assign res.OVF   = ovf_q;
    assign res.BUSY  = (state_q == CONV);
    assign res.NEG   = neg_q;

endmodule
